// File: rtl/cacheline_arbiter_pkg.sv
// Shared types and constants for the cache-line memory arbiter.
// Both caches use 32-byte lines that move over a 64-bit burst port.
package cacheline_arb_types;

   localparam int LINE_BITS = 256;
   localparam int BEAT_BITS = 64;
   localparam int BEATS     = LINE_BITS / BEAT_BITS;

   localparam logic [31:0] LINE_ADDR_MASK = 32'hFFFF_FFE0;

   typedef enum logic [2:0] {IDLE, I_READ, D_READ, D_WRITE, DONE} arb_state_t;
   typedef enum logic {INST, DATA} grant_t;

   function automatic logic [31:0] line_align(input logic [31:0] addr);
      return addr & LINE_ADDR_MASK;
   endfunction

endpackage

// File: rtl/cacheline_arbiter_buffer.sv
// Line buffer: assembles read beats into a full line and selects
// the current beat of an outgoing line, both indexed by one beat counter.
module cacheline_buffer #(
   parameter int LINE_BITS = 256,
   parameter int BEAT_BITS = 64
) (
   input  logic                                     clk,
   input  logic                                     i_clr,
   input  logic                                     i_wr_en,
   input  logic [$clog2(LINE_BITS/BEAT_BITS)-1:0]   i_idx,
   input  logic [BEAT_BITS-1:0]                     i_wr_beat,
   output logic [LINE_BITS-1:0]                     o_line,
   input  logic [LINE_BITS-1:0]                     i_sel_line,
   output logic [BEAT_BITS-1:0]                     o_sel_beat
);

   logic [LINE_BITS-1:0] r_line;

   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_line <= '0;
      end else if (i_wr_en) begin
         r_line[BEAT_BITS*i_idx +: BEAT_BITS] <= i_wr_beat;
      end
   end

   assign o_line     = r_line;
   assign o_sel_beat = i_sel_line[BEAT_BITS*i_idx +: BEAT_BITS];

endmodule

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one burst memory port between the
// instruction cache (reads) and the data cache (reads and writebacks).
module cacheline_arbiter #(
   parameter int LINE_BITS = cacheline_arb_types::LINE_BITS,
   parameter int BEAT_BITS = cacheline_arb_types::BEAT_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_read,
   input  logic [31:0]          i_addr,
   output logic [LINE_BITS-1:0] i_rdata,
   output logic                 i_resp,
   input  logic                 d_read,
   input  logic                 d_write,
   input  logic [31:0]          d_addr,
   input  logic [LINE_BITS-1:0] d_wdata,
   output logic [LINE_BITS-1:0] d_rdata,
   output logic                 d_resp,
   output logic                 pmem_read,
   output logic                 pmem_write,
   output logic [31:0]          pmem_addr,
   output logic [BEAT_BITS-1:0] pmem_wdata,
   input  logic [BEAT_BITS-1:0] pmem_rdata,
   input  logic                 pmem_resp
);

   localparam int BEATS = LINE_BITS / BEAT_BITS;
   localparam int IDX_W = $clog2(BEATS);

   import cacheline_arb_types::*;

   arb_state_t             r_state, w_next;
   grant_t                 r_last, w_grant;
   logic                   w_load, w_adv, w_cap, w_d_req, w_last_beat;
   logic [31:0]            r_addr, w_addr;
   logic [IDX_W-1:0]       r_beat;
   logic [LINE_BITS-1:0]   w_line;
   logic [BEAT_BITS-1:0]   w_wbeat;

   assign w_d_req     = d_read | d_write;
   assign w_last_beat = (r_beat == IDX_W'(BEATS-1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_last  <= INST;
         r_addr  <= '0;
         r_beat  <= '0;
      end else begin
         r_state <= w_next;
         if (w_load) begin
            r_last <= w_grant;
            r_addr <= w_addr;
            r_beat <= '0;
         end else if (w_adv) begin
            r_beat <= r_beat + 1'b1;
         end
      end
   end

   // Contention goes to the side not served last; after reset that is data.
   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_grant    = r_last;
      w_addr     = r_addr;
      w_adv      = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      i_resp     = 1'b0;
      d_resp     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_d_req && (!i_read || r_last == INST)) begin
               w_load  = 1'b1;
               w_grant = DATA;
               w_addr  = line_align(d_addr);
               w_next  = d_write ? D_WRITE : D_READ;
            end else if (i_read) begin
               w_load  = 1'b1;
               w_grant = INST;
               w_addr  = line_align(i_addr);
               w_next  = I_READ;
            end
         end
         I_READ, D_READ: begin
            pmem_read = 1'b1;
            w_adv     = pmem_resp;
            if (pmem_resp && w_last_beat) w_next = DONE;
         end
         D_WRITE: begin
            pmem_write = 1'b1;
            w_adv      = pmem_resp;
            if (pmem_resp && w_last_beat) w_next = DONE;
         end
         DONE: begin
            i_resp = (r_last == INST);
            d_resp = (r_last == DATA);
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_cap = pmem_read & pmem_resp;

   cacheline_buffer #(
      .LINE_BITS (LINE_BITS),
      .BEAT_BITS (BEAT_BITS)
   ) u_buf (
      .clk        (clk),
      .i_clr      (rst),
      .i_wr_en    (w_cap),
      .i_idx      (r_beat),
      .i_wr_beat  (pmem_rdata),
      .o_line     (w_line),
      .i_sel_line (d_wdata),
      .o_sel_beat (w_wbeat)
   );

   assign pmem_addr  = r_addr;
   assign pmem_wdata = pmem_write ? w_wbeat : '0;
   assign i_rdata    = w_line;
   assign d_rdata    = w_line;

   a_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Bench for cacheline_arbiter: beat-level memory model, requester tasks
// and an in-order scoreboard of expected transactions.
module tb_cacheline_arbiter;
   import cacheline_arb_types::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_read, d_read, d_write;
   logic [31:0]  i_addr, d_addr;
   logic [255:0] d_wdata, i_rdata, d_rdata;
   logic         i_resp, d_resp;
   logic         pmem_read, pmem_write, pmem_resp;
   logic [31:0]  pmem_addr;
   logic [63:0]  pmem_wdata, pmem_rdata;

   always #5 clk = ~clk;

   cacheline_arbiter dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   typedef struct {
      logic         is_inst;
      logic         is_write;
      logic [31:0]  addr;
      logic [255:0] line;
   } sb_t;

   typedef struct {
      logic         is_inst;
      logic         is_write;
      logic [31:0]  addr;
      logic [255:0] wdata;
      int           gap_max;
      logic         stray;
      logic [31:0]  exp_paddr;
      logic [255:0] exp_line;
   } vec_t;

   sb_t    sb[$];
   vec_t   vecs[6];
   int     n_tests = 0;
   int     n_fail  = 0;
   int     gap_max = 0;
   logic   stray   = 1'b0;
   int     mcnt    = 0;
   int     gap_cnt = 0;
   logic   prev_strobe = 1'b0;
   grant_t m_last;

   function automatic logic [63:0] mem_beat(input logic [31:0] a, input int k);
      logic [7:0] b;
      b = 8'h11 * 8'(k + 1);
      return {8{b}} ^ {32'h0, a};
   endfunction

   function automatic logic [255:0] mem_line(input logic [31:0] a);
      logic [255:0] l;
      for (int k = 0; k < 4; k++) l[k*64 +: 64] = mem_beat(a, k);
      return l;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h, required %0h", name, act, exp);
      end
   endtask

   // Memory model: one beat per resp, random gaps, optional stray resp while idle.
   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (pmem_read || pmem_write) begin
            if (!prev_strobe) begin
               mcnt    = 0;
               gap_cnt = $urandom_range(gap_max, 0);
            end
            prev_strobe = 1'b1;
            if (sb.size() == 0) begin
               chk("burst_unexpected", 1'b1, 1'b0);
            end else begin
               chk("strobe", {pmem_read, pmem_write}, sb[0].is_write ? 2'b01 : 2'b10);
               chk("pmem_addr", pmem_addr, sb[0].addr);
            end
            if (gap_cnt > 0) begin
               gap_cnt--;
               pmem_resp  = 1'b0;
               pmem_rdata = {$urandom, $urandom};
            end else begin
               pmem_resp  = 1'b1;
               pmem_rdata = mem_beat(pmem_addr, mcnt);
               if (pmem_write && sb.size() > 0 && mcnt < 4)
                  chk("pmem_wdata", pmem_wdata, sb[0].line[mcnt*64 +: 64]);
               mcnt++;
               gap_cnt = $urandom_range(gap_max, 0);
            end
         end else begin
            prev_strobe = 1'b0;
            pmem_resp   = stray;
            pmem_rdata  = {$urandom, $urandom};
         end
      end
   end

   // Response monitor: every resp must match the head of the scoreboard.
   initial begin
      sb_t e;
      forever begin
         @(negedge clk);
         if (i_resp || d_resp) begin
            if (sb.size() == 0) begin
               chk("resp_unexpected", {i_resp, d_resp}, 2'b00);
            end else begin
               e = sb.pop_front();
               chk("resp_side", {i_resp, d_resp}, e.is_inst ? 2'b10 : 2'b01);
               chk("beats", mcnt, 4);
               chk("strobe_in_resp", {pmem_read, pmem_write}, 2'b00);
               if (!e.is_write)
                  chk(e.is_inst ? "i_rdata" : "d_rdata", e.is_inst ? i_rdata : d_rdata, e.line);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: actual running, required finished");
      $fatal(1, "watchdog expired");
   end

   task automatic do_req(input logic is_inst, input logic is_write, input logic [31:0] addr,
                         input logic [255:0] wdata, input bit chk_lat);
      int lat;
      bit got;
      if (is_inst) begin
         i_read = 1'b1;
         i_addr = addr;
      end else begin
         d_read  = !is_write;
         d_write = is_write;
         d_addr  = addr;
         d_wdata = wdata;
      end
      lat = 1;
      got = 1'b0;
      while (!got && lat < 400) begin
         @(negedge clk);
         lat++;
         got = is_inst ? i_resp : d_resp;
      end
      if (!got) chk("req_timeout", 1'b0, 1'b1);
      if (is_inst) i_read = 1'b0;
      else begin
         d_read  = 1'b0;
         d_write = 1'b0;
      end
      if (chk_lat) chk("latency", lat, 6);
      @(negedge clk);
      chk("resp_pulse", is_inst ? i_resp : d_resp, 1'b0);
   endtask

   task automatic push(input logic is_inst, input logic is_write, input logic [31:0] paddr,
                       input logic [255:0] line);
      sb.push_back('{is_inst, is_write, paddr, line});
   endtask

   initial begin
      logic [31:0] ia, da;
      int          waited;
      bit          seen;
      rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_i_resp", i_resp, 1'b0);
      chk("rst_d_resp", d_resp, 1'b0);
      chk("rst_pmem_read", pmem_read, 1'b0);
      chk("rst_pmem_write", pmem_write, 1'b0);
      chk("rst_pmem_addr", pmem_addr, 32'h0);
      chk("rst_pmem_wdata", pmem_wdata, 64'h0);
      chk("rst_i_rdata", i_rdata, 256'h0);
      chk("rst_d_rdata", d_rdata, 256'h0);
      rst    = 1'b0;
      m_last = INST;
      @(negedge clk);

      // Simultaneous rounds; a solo data read before round 2 flips priority.
      for (int r = 0; r < 4; r++) begin
         if (r == 2) begin
            push(1'b0, 1'b0, 32'h0002_0000, mem_line(32'h0002_0000));
            do_req(1'b0, 1'b0, 32'h0002_0004, '0, 1'b1);
            m_last = DATA;
         end
         ia = 32'h0000_4004 + 32'(r) * 32'h100;
         da = 32'h0001_0008 + 32'(r) * 32'h40;
         if (m_last == INST) begin
            push(1'b0, 1'b0, da & 32'hFFFF_FFE0, mem_line(da & 32'hFFFF_FFE0));
            push(1'b1, 1'b0, ia & 32'hFFFF_FFE0, mem_line(ia & 32'hFFFF_FFE0));
            m_last = INST;
         end else begin
            push(1'b1, 1'b0, ia & 32'hFFFF_FFE0, mem_line(ia & 32'hFFFF_FFE0));
            push(1'b0, 1'b0, da & 32'hFFFF_FFE0, mem_line(da & 32'hFFFF_FFE0));
            m_last = DATA;
         end
         fork
            do_req(1'b1, 1'b0, ia, '0, 1'b0);
            do_req(1'b0, 1'b0, da, '0, 1'b0);
         join
      end

      vecs[0] = '{1'b1, 1'b0, 32'h0000_1044, '0, 0, 1'b0, 32'h0000_1040, mem_line(32'h0000_1040)};
      vecs[1] = '{1'b0, 1'b1, 32'h8000_0020,
                  256'h3333333333333333_2222222222222222_1111111111111111_0000000000000000,
                  0, 1'b0, 32'h8000_0020,
                  256'h3333333333333333_2222222222222222_1111111111111111_0000000000000000};
      vecs[2] = '{1'b0, 1'b0, 32'h0000_2ABC, '0, 5, 1'b1, 32'h0000_2AA0, mem_line(32'h0000_2AA0)};
      vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, '0, 2, 1'b0, 32'hFFFF_FFE0, mem_line(32'hFFFF_FFE0)};
      vecs[4] = '{1'b0, 1'b1, 32'h1234_567F, '0, 3, 1'b1, 32'h1234_5660, '0};
      vecs[4].wdata    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      vecs[4].exp_line = vecs[4].wdata;
      vecs[5] = '{1'b0, 1'b0, 32'h8000_0020, '0, 0, 1'b0, 32'h8000_0020, mem_line(32'h8000_0020)};

      foreach (vecs[i]) begin
         gap_max = vecs[i].gap_max;
         stray   = vecs[i].stray;
         push(vecs[i].is_inst, vecs[i].is_write, vecs[i].exp_paddr, vecs[i].exp_line);
         do_req(vecs[i].is_inst, vecs[i].is_write, vecs[i].addr, vecs[i].wdata, vecs[i].gap_max == 0);
         m_last  = vecs[i].is_inst ? INST : DATA;
         gap_max = 0;
         stray   = 1'b0;
      end

      // Reset in the middle of an instruction burst.
      push(1'b1, 1'b0, 32'h0000_3000, mem_line(32'h0000_3000));
      i_read = 1'b1;
      i_addr = 32'h0000_3008;
      waited = 0;
      while (!(pmem_read && mcnt == 2) && waited < 50) begin
         @(negedge clk);
         #1;
         waited++;
      end
      chk("abort_reach_beat2", mcnt, 2);
      @(negedge clk);
      rst    = 1'b1;
      i_read = 1'b0;
      @(negedge clk);
      chk("abort_pmem_read", pmem_read, 1'b0);
      chk("abort_i_resp", i_resp, 1'b0);
      chk("abort_state", dut.r_state, IDLE);
      chk("abort_rdata_clr", i_rdata, 256'h0);
      rst = 1'b0;
      void'(sb.pop_front());
      m_last = INST;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (i_resp) seen = 1'b1;
      end
      chk("abort_no_resp", seen, 1'b0);
      push(1'b1, 1'b0, 32'h0000_3000, mem_line(32'h0000_3000));
      do_req(1'b1, 1'b0, 32'h0000_3008, '0, 1'b1);

      // Data request raised while an instruction burst is in flight.
      gap_max = 1;
      push(1'b1, 1'b0, 32'h0000_5000, mem_line(32'h0000_5000));
      push(1'b0, 1'b0, 32'h0000_6000, mem_line(32'h0000_6000));
      fork
         do_req(1'b1, 1'b0, 32'h0000_5010, '0, 1'b0);
         begin
            repeat (2) @(negedge clk);
            do_req(1'b0, 1'b0, 32'h0000_6018, '0, 1'b0);
         end
      join
      gap_max = 0;

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
